// File: rtl/digit_scan_decoder.sv
// digit_scan_decoder: registered one-hot digit enable from a manual index or a prescaled auto-scan counter.
// Define DIGIT_SCAN_BLANK_EN to insert a one-cycle blank on every auto-scan advance.
module digit_scan_decoder #(
    parameter int SEL_W      = 3,
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE   = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     number,
    output logic [2**SEL_W-1:0]  res,
    output logic [SEL_W-1:0]     cur_sel,
    output logic                 step,
    output logic                 range_err
);
    localparam int N = 2**SEL_W;
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [SEL_W:0] LAST = (SEL_W+1)'(NUM_DIGITS - 1);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    logic [PW-1:0]    pre_q, pre_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [N-1:0]     res_q, res_d;
    logic             step_q, step_d, err_q, err_d, mode_q, adv;

    always_comb begin
        // a mode change forces mode_q != mode, so it always beats the terminal count
        adv    = en && mode && mode_q && pre_q == PMAX;
        pre_d  = pre_q;
        sel_d  = sel_q;
        err_d  = err_q;
        step_d = 1'b0;
        res_d  = '0;
        if (en) begin
            err_d  = !mode && {1'b0, number} > LAST;
            sel_d  = !mode ? number : adv ? ({1'b0, sel_q} >= LAST ? '0 : sel_q + 1'b1) : sel_q;
            pre_d  = (!mode || mode != mode_q || adv) ? '0 : pre_q + 1'b1;
            step_d = adv;
            res_d  = {1'b0, sel_d} > LAST ? '0 : N'(1) << sel_d;
`ifdef DIGIT_SCAN_BLANK_EN
            if (adv) res_d = '0;
`else
            res_d = res_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q  <= '0;
            sel_q  <= '0;
            res_q  <= '0;
            step_q <= 1'b0;
            err_q  <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            sel_q  <= sel_d;
            res_q  <= res_d;
            step_q <= step_d;
            err_q  <= err_d;
            mode_q <= mode;
        end
    end

    assign res       = res_q;
    assign cur_sel   = sel_q;
    assign step      = step_q;
    assign range_err = err_q;
endmodule
